// File: rtl/clk_div_bank_pkg.sv
// Shared constants and helpers for the clock divider bank.
package clk_div_bank_pkg;

   localparam int unsigned MIN_RATIO = 2;

   // High-phase length of a divide-by-n period; odd ratios get the extra high cycle.
   function automatic logic [31:0] ceil_half(input logic [31:0] n);
      return (n >> 1) + {31'd0, n[0]};
   endfunction

endpackage

// File: rtl/clk_div_bank_chan.sv
// One divider channel: a counter that wraps at the active ratio, a pending ratio
// slot, and duty/strobe outputs decoded from the counter's next state.
module clk_div_chan
   import clk_div_bank_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int RST_RATIO = 50
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             en,
   input  logic             sync_start,
   input  logic             cfg_load,
   input  logic [CNT_W-1:0] cfg_ratio,
   output logic             clk_out,
   output logic             stb,
   output logic             cfg_err
);

   logic [CNT_W-1:0] cnt, ratio, pend_ratio;
   logic [CNT_W-1:0] cnt_nxt, ratio_nxt, pend_ratio_nxt, load_val;
   logic             pend, pend_nxt, run;
   logic             bad, restart, wrap, apply;

   always_comb begin
      bad      = cfg_ratio < CNT_W'(MIN_RATIO);
      load_val = bad ? CNT_W'(MIN_RATIO) : cfg_ratio;
      // run is low on the first enabled edge, so the counter starts from 0 then
      restart  = en && (sync_start || !run);
      wrap     = en && run && !sync_start && (cnt == ratio - CNT_W'(1));
      apply    = !en || restart || wrap;

      pend_ratio_nxt = cfg_load ? load_val : pend_ratio;
      pend_nxt       = pend || cfg_load;
      ratio_nxt      = ratio;
      // A load in the same cycle as an apply point passes straight through.
      if (apply && pend_nxt) begin
         ratio_nxt = pend_ratio_nxt;
         pend_nxt  = 1'b0;
      end

      cnt_nxt = apply ? '0 : cnt + CNT_W'(1);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt        <= '0;
         ratio      <= CNT_W'(RST_RATIO);
         pend_ratio <= CNT_W'(RST_RATIO);
         pend       <= 1'b0;
         run        <= 1'b0;
         clk_out    <= 1'b0;
         stb        <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         ratio      <= ratio_nxt;
         pend_ratio <= pend_ratio_nxt;
         pend       <= pend_nxt;
         run        <= en;
         clk_out    <= en && (32'(cnt_nxt) < ceil_half(32'(ratio_nxt)));
         stb        <= en && (cnt_nxt == ratio_nxt - CNT_W'(1));
         if (cfg_load)
            cfg_err <= bad;
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent integer clock dividers sharing one phase-restart pulse.
// clk_out is plain data on sys_clk; consumers should prefer the stb enables.
module clk_div_bank
   import clk_div_bank_pkg::*;
#(
   parameter int CH_NUM    = 3,
   parameter int CNT_W     = 16,
   parameter int RST_RATIO = 50
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic [CH_NUM-1:0]       en,
   input  logic                    sync_start,
   input  logic [CH_NUM-1:0]       cfg_load,
   input  logic [CH_NUM*CNT_W-1:0] cfg_ratio,
   output logic [CH_NUM-1:0]       clk_out,
   output logic [CH_NUM-1:0]       stb,
   output logic [CH_NUM-1:0]       cfg_err
);

   for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
      clk_div_chan #(
         .CNT_W     (CNT_W),
         .RST_RATIO (RST_RATIO)
      ) u_chan (
         .sys_clk    (sys_clk),
         .sys_rst_n  (sys_rst_n),
         .en         (en[i]),
         .sync_start (sync_start),
         .cfg_load   (cfg_load[i]),
         .cfg_ratio  (cfg_ratio[i*CNT_W +: CNT_W]),
         .clk_out    (clk_out[i]),
         .stb        (stb[i]),
         .cfg_err    (cfg_err[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: expected waveforms come from the ratio and a
// known counter phase; outputs are sampled on the falling edge of sys_clk.
module tb_clk_div_bank;

   localparam int CH_NUM = 3;
   localparam int CNT_W  = 16;

   logic                    sys_clk = 1'b0;
   logic                    sys_rst_n;
   logic [CH_NUM-1:0]       en;
   logic                    sync_start;
   logic [CH_NUM-1:0]       cfg_load;
   logic [CH_NUM*CNT_W-1:0] cfg_ratio;
   logic [CH_NUM-1:0]       clk_out;
   logic [CH_NUM-1:0]       stb;
   logic [CH_NUM-1:0]       cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   clk_div_bank #(
      .CH_NUM    (CH_NUM),
      .CNT_W     (CNT_W),
      .RST_RATIO (50)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .en         (en),
      .sync_start (sync_start),
      .cfg_load   (cfg_load),
      .cfg_ratio  (cfg_ratio),
      .clk_out    (clk_out),
      .stb        (stb),
      .cfg_err    (cfg_err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_ratio(input int ch, input int val);
      cfg_ratio[ch*CNT_W +: CNT_W] = CNT_W'(val);
   endtask

   // Compare len cycles of one channel against the ideal waveform, starting at phase start.
   task automatic measure(input int ch, input int n, input int start, input int len);
      int ph, bad, hi, hi_exp;
      bad = 0; hi = 0; hi_exp = 0;
      for (int k = 0; k < len; k++) begin
         ph = (start + k) % n;
         if (clk_out[ch] !== (ph < (n + 1) / 2)) bad++;
         if (stb[ch] !== (ph == n - 1)) bad++;
         hi += int'(clk_out[ch]);
         hi_exp += int'(ph < (n + 1) / 2);
         @(negedge sys_clk);
      end
      check($sformatf("pattern ch%0d n%0d", ch, n), bad, 0);
      check($sformatf("high_cycles ch%0d n%0d", ch, n), hi, hi_exp);
   endtask

   task automatic wait_stb(input int ch, output int cyc);
      cyc = 0;
      while (stb[ch] !== 1'b1 && cyc < 300) begin
         @(negedge sys_clk);
         cyc++;
      end
      if (cyc >= 300) check($sformatf("stb_timeout ch%0d", ch), stb[ch], 1);
   endtask

   task automatic load_at_wrap(input int ch, input int val, output int cyc);
      wait_stb(ch, cyc);
      cfg_load[ch] = 1'b1;
      set_ratio(ch, val);
      @(negedge sys_clk);
      cfg_load = '0;
   endtask

   initial begin
      int c, bad;
      sys_rst_n  = 1'b0;
      en         = '0;
      sync_start = 1'b0;
      cfg_load   = '0;
      cfg_ratio  = '0;

      // reset state, then default ratio 50 on release
      @(negedge sys_clk);
      check("rst clk_out", clk_out, 0);
      check("rst stb", stb, 0);
      check("rst cfg_err", cfg_err, 0);
      sys_rst_n = 1'b1;
      en = 3'b111;
      @(negedge sys_clk);
      check("start clk_out", clk_out, 3'b111);
      check("start stb", stb, 0);
      measure(0, 50, 0, 50);

      // ratios 100/100/10 loaded while disabled
      en = '0;
      cfg_load = 3'b111;
      set_ratio(0, 100); set_ratio(1, 100); set_ratio(2, 10);
      @(negedge sys_clk);
      cfg_load = '0;
      check("dis clk_out", clk_out, 0);
      check("dis stb", stb, 0);
      en = 3'b111;
      @(negedge sys_clk);
      check("en clk_out", clk_out, 3'b111);
      measure(0, 100, 0, 100);
      measure(2, 10, 0, 10);
      measure(1, 100, 10, 90);

      // ratio 7 on ch2 mid-period: old period finishes first
      repeat (3) @(negedge sys_clk);
      cfg_load[2] = 1'b1;
      set_ratio(2, 7);
      @(negedge sys_clk);
      cfg_load = '0;
      wait_stb(2, c);
      check("ch2 old period tail", c, 5);
      @(negedge sys_clk);
      measure(2, 7, 0, 14);

      // load-through at the wrap cycle
      load_at_wrap(2, 4, c);
      check("ch2 wrap wait", c, 6);
      measure(2, 4, 0, 8);

      // illegal ratios clamp to 2 and set the sticky flag; legal load clears it
      load_at_wrap(1, 1, c);
      check("err after 1", cfg_err, 3'b010);
      measure(1, 2, 0, 6);
      load_at_wrap(1, 8, c);
      check("wait n2 a", c, 1);
      check("err cleared a", cfg_err, 0);
      measure(1, 8, 0, 8);
      load_at_wrap(1, 0, c);
      check("wait n8", c, 7);
      check("err after 0", cfg_err, 3'b010);
      measure(1, 2, 0, 4);
      load_at_wrap(1, 8, c);
      check("wait n2 b", c, 1);
      check("err cleared b", cfg_err, 0);
      measure(1, 8, 0, 8);

      // two loads before the wrap: last one wins
      repeat (2) @(negedge sys_clk);
      cfg_load[1] = 1'b1;
      set_ratio(1, 5);
      @(negedge sys_clk);
      set_ratio(1, 3);
      @(negedge sys_clk);
      cfg_load = '0;
      wait_stb(1, c);
      check("lww tail", c, 3);
      @(negedge sys_clk);
      measure(1, 3, 0, 6);

      // sync_start on a ch1 wrap, with a load-through on ch2
      wait_stb(1, c);
      check("sync wait", c, 2);
      sync_start = 1'b1;
      cfg_load[2] = 1'b1;
      set_ratio(2, 6);
      @(negedge sys_clk);
      sync_start = 1'b0;
      cfg_load = '0;
      check("sync clk_out", clk_out, 3'b111);
      check("sync stb", stb, 0);
      measure(2, 6, 0, 12);
      measure(1, 3, 12, 12);
      measure(0, 100, 24, 76);

      // ch0 disabled for 13 cycles
      en = 3'b110;
      bad = 0;
      for (int k = 0; k < 13; k++) begin
         @(negedge sys_clk);
         if (clk_out[0] !== 1'b0 || stb[0] !== 1'b0) bad++;
      end
      check("ch0 disabled outputs", bad, 0);
      en = 3'b111;
      @(negedge sys_clk);
      check("ch0 reenable clk", clk_out[0], 1);
      check("ch0 reenable stb", stb[0], 0);
      measure(0, 100, 0, 100);
      measure(1, 3, 214, 6);
      measure(2, 6, 220, 6);

      // mid-period reset restores ratio 50 and clears the flag
      cfg_load[2] = 1'b1;
      set_ratio(2, 1);
      @(negedge sys_clk);
      cfg_load = '0;
      check("err ch2 set", cfg_err, 3'b100);
      repeat (30) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      check("async rst clk_out", clk_out, 0);
      check("async rst stb", stb, 0);
      check("async rst cfg_err", cfg_err, 0);
      bad = 0;
      repeat (3) begin
         @(negedge sys_clk);
         if (clk_out !== 3'b000 || stb !== 3'b000) bad++;
      end
      check("held rst outputs", bad, 0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      check("rerun clk_out", clk_out, 3'b111);
      measure(0, 50, 0, 50);
      measure(2, 50, 50, 50);
      measure(1, 50, 100, 50);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter CH_NUM, default 3: number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 16: counter and ratio width per channel.
REQ-003 Parameter RST_RATIO, default 50: active divide ratio of every channel after reset.
REQ-004 sys_clk  in  1: single clock for all logic, rising edge.
REQ-005 sys_rst_n  in  1: asynchronous active-low reset.
REQ-006 en  in  CH_NUM: per-channel run enable.
REQ-007 sync_start  in  1: one-cycle pulse that restarts all enabled channels in phase.
REQ-008 cfg_load  in  CH_NUM: per-channel one-cycle strobe to capture a new ratio.
REQ-009 cfg_ratio  in  CH_NUM*CNT_W: new full-period ratio N per channel, channel i at bits [i*CNT_W +: CNT_W].
REQ-010 clk_out  out  CH_NUM: divided clock per channel, registered.
REQ-011 stb  out  CH_NUM: one-cycle enable strobe per channel period, registered.
REQ-012 cfg_err  out  CH_NUM: sticky flag per channel, set when an illegal ratio is loaded.

Function
REQ-013 Each channel SHALL hold a counter cnt (0..N-1), an active ratio N, a pending ratio P, and a pending flag.
REQ-014 While en[i]=1 and no sync_start occurs, cnt SHALL increment by 1 each cycle and wrap from N-1 to 0.
REQ-015 clk_out[i] SHALL be high exactly in the cycles where cnt < ceil(N/2), giving a 50% duty cycle for even N and one extra high cycle for odd N.
REQ-016 stb[i] SHALL be high exactly in the cycles where cnt = N-1.
REQ-017 clk_out and stb SHALL be registered from the counter's next-state value, so both align with cnt with zero added latency.
REQ-018 While en[i]=0, cnt SHALL be held at 0 and clk_out[i] and stb[i] SHALL be 0.
REQ-019 On the first enabled cycle after en[i] rises, cnt SHALL be 0 and clk_out[i] SHALL be 1.
REQ-020 When cfg_load[i]=1 and cfg_ratio_i >= 2, the value SHALL be stored in P and the pending flag set.
REQ-021 When cfg_load[i]=1 and cfg_ratio_i < 2, cfg_err[i] SHALL be set, P SHALL be 2, and the pending flag SHALL be set.
REQ-022 A legal cfg_load[i] SHALL clear cfg_err[i].
REQ-023 A pending ratio SHALL become active N only at the wrap (cnt = N-1 to 0), at sync_start, or immediately when en[i]=0; the pending flag then clears.
REQ-024 If cfg_load[i] coincides with the wrap cycle, the new value SHALL take effect at that wrap (load-through).
REQ-025 A second cfg_load before the apply point SHALL overwrite P; last write wins.
REQ-026 sync_start SHALL force cnt to 0 on all enabled channels on the next edge and apply any pending ratios.
REQ-027 sync_start SHALL have priority over a wrap occurring in the same cycle.
REQ-028 sync_start SHALL have no effect on disabled channels.
REQ-029 If N changes to a value <= cnt via sync or disable, cnt SHALL restart at 0; otherwise cnt SHALL never exceed N-1.
REQ-030 Channels SHALL be fully independent except for the shared sync_start.

Reset
REQ-031 On sys_rst_n low, asynchronously: cnt=0, N=P=RST_RATIO, pending=0, clk_out=0, stb=0, cfg_err=0.
REQ-032 Reset asserted mid-period SHALL abort the period with no stb pulse emitted.
REQ-033 After reset release, each enabled channel SHALL start as in REQ-019.

Structure
REQ-034 A shared package SHALL hold the MIN_RATIO=2 constant and the ceil-half function used for duty decoding.
REQ-035 One sub-module, clk_div_chan, SHALL implement a single channel, instantiated CH_NUM times via generate.
REQ-036 No clock SHALL be gated or generated on the sys_clk net; clk_out is a data signal, and stb is the preferred consumer interface.

Verification
REQ-037 Reset release, en=3'b111, ratios 100/100/10 -> ch0/ch1 clk_out 50 high/50 low, stb every 100 cycles; ch2 period 10.
REQ-038 cfg_ratio=7 loaded on ch2 -> clk_out 4 high/3 low, stb once per 7 cycles; change visible only after the current period wraps.
REQ-039 cfg_load with ratio 1 or 0 -> cfg_err=1, ratio 2 (clk_out toggles every cycle, stb every 2nd cycle); then load 8 -> cfg_err cleared.
REQ-040 sync_start mid-period on the same cycle as a ch1 wrap -> all enabled counters 0 next cycle, clk_out rising together, no stb on ch1 that cycle.
REQ-041 en[0] dropped for 13 cycles then raised -> outputs 0 while disabled; first enabled cycle has cnt=0 and clk_out=1.
REQ-042 sys_rst_n pulsed low mid-period -> all outputs 0 immediately, N=50 restored, no stray stb.
